// File: rtl/amo_data_mem_if.sv
// Request/response bus between the core's memunit (master) and the data RAM responder (slave).
interface core_data_if #(
  parameter int AW = 32
);
  logic          valid;
  logic          ready;
  logic [AW-1:0] addr;
  logic          wen;
  logic [63:0]   wdata;
  logic [7:0]    wmask;
  logic          is_amo;
  logic [4:0]    amoop;
  logic          aq;
  logic          rl;
  logic [2:0]    funct3;
  logic          rvalid;
  logic [63:0]   rdata;

  modport master (
    output valid, addr, wen, wdata, wmask, is_amo, amoop, aq, rl, funct3,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, addr, wen, wdata, wmask, is_amo, amoop, aq, rl, funct3,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/amo_data_mem.sv
// Data RAM responder: loads, byte-masked stores, RV64A AMOs and LR/SC with a single reservation.
// amoop uses the RV64A funct5 encoding; one request in flight at a time.
module amo_data_mem #(
  parameter int DEPTH     = 4096,
  parameter int ADDR_LSB  = 3,
  parameter     INIT_FILE = ""
) (
  input logic        clk,
  input logic        rst,
  core_data_if.slave membus
);
  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SWAP = 5'b00001;
  localparam logic [4:0] OP_LR   = 5'b00010;
  localparam logic [4:0] OP_SC   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_OR   = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01100;
  localparam logic [4:0] OP_MIN  = 5'b10000;
  localparam logic [4:0] OP_MAX  = 5'b10100;
  localparam logic [4:0] OP_MINU = 5'b11000;
  localparam logic [4:0] OP_MAXU = 5'b11100;

  typedef enum logic [1:0] {IDLE, RESP, AMO_WB} state_t;

  state_t           state, state_next;
  logic [63:0]      ram [DEPTH];
  logic [63:0]      old_word;
  logic [IDX_W-1:0] req_idx;
  logic             req_lane, req_wen, req_amo;
  logic [63:0]      req_wdata;
  logic [7:0]       req_wmask;
  logic [4:0]       req_op;
  logic [1:0]       req_width;
  logic             rsv_vld;
  logic [IDX_W-1:0] rsv_idx;
  logic             accept, word_op, is_lr, is_sc, rsv_hit, ram_we, resp_valid;
  logic [63:0]      ram_wdata, resp_data, sc_word, amo_new, amo_result;
  logic [31:0]      a32, b32;
  logic [63:0]      op_a, op_b, alu_r;
  logic             lt_s, lt_u;
  logic             unused_bits;

  assign accept   = (state == IDLE) && membus.valid && !rst;
  assign word_op  = (req_width == 2'b10);
  assign is_lr    = req_amo && (req_op == OP_LR);
  assign is_sc    = req_amo && (req_op == OP_SC);
  assign rsv_hit  = rsv_vld && (rsv_idx == req_idx);
  assign sc_word  = (word_op && req_lane) ? {31'h0, !rsv_hit, 32'h0} : {63'h0, !rsv_hit};

  assign membus.ready  = (state == IDLE) && !rst;
  assign membus.rvalid = resp_valid && !rst;
  assign membus.rdata  = (resp_valid && !rst) ? resp_data : 64'h0;

  assign unused_bits = ^{membus.aq, membus.rl, membus.funct3[2], membus.addr};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_idx   <= '0;
      req_lane  <= 1'b0;
      req_wen   <= 1'b0;
      req_amo   <= 1'b0;
      req_wdata <= 64'h0;
      req_wmask <= 8'h0;
      req_op    <= 5'h0;
      req_width <= 2'b0;
      amo_new   <= 64'h0;
    end else begin
      if (accept) begin
        req_idx   <= membus.addr[ADDR_LSB +: IDX_W];
        req_lane  <= membus.addr[2];
        req_wen   <= membus.wen;
        req_amo   <= membus.is_amo;
        req_wdata <= membus.wdata;
        req_wmask <= membus.wmask;
        req_op    <= membus.amoop;
        req_width <= membus.funct3[1:0];
      end
      if (state == RESP) amo_new <= amo_result;
    end
  end

  // RAM port: reads only on a handshake, writes only in RESP/AMO_WB, so they never collide.
  // A reset in the write cycle abandons the op and leaves the word untouched.
  always_ff @(posedge clk) begin
    if (accept) old_word <= ram[membus.addr[ADDR_LSB +: IDX_W]];
    if (ram_we && !rst) begin
      for (int b = 0; b < 8; b++) begin
        if (req_wmask[b]) ram[req_idx][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsv_vld <= 1'b0;
      rsv_idx <= '0;
    end else if (state == RESP && is_lr) begin
      rsv_vld <= 1'b1;
      rsv_idx <= req_idx;
    end else if ((state == RESP && is_sc) || (ram_we && rsv_hit)) begin
      rsv_vld <= 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    ram_we     = 1'b0;
    ram_wdata  = req_wdata;
    resp_valid = 1'b0;
    resp_data  = old_word;
    case (state)
      IDLE: if (accept) state_next = RESP;
      RESP: begin
        if (req_amo && !is_lr && !is_sc) begin
          state_next = AMO_WB;
        end else begin
          state_next = IDLE;
          resp_valid = 1'b1;
          if (is_sc) begin
            ram_we    = rsv_hit;
            resp_data = sc_word;
          end else if (!req_amo) begin
            ram_we = req_wen;
          end
        end
      end
      AMO_WB: begin
        state_next = IDLE;
        ram_we     = 1'b1;
        ram_wdata  = amo_new;
        resp_valid = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Word AMOs work on the addressed lane; the result is replicated and wmask picks the lane.
  always_comb begin
    a32 = req_lane ? old_word[63:32] : old_word[31:0];
    b32 = req_lane ? req_wdata[63:32] : req_wdata[31:0];
    if (word_op) begin
      op_a = {32'h0, a32};
      op_b = {32'h0, b32};
      lt_s = $signed(a32) < $signed(b32);
    end else begin
      op_a = old_word;
      op_b = req_wdata;
      lt_s = $signed(old_word) < $signed(req_wdata);
    end
    lt_u = op_a < op_b;
    case (req_op)
      OP_SWAP: alu_r = op_b;
      OP_ADD:  alu_r = op_a + op_b;
      OP_XOR:  alu_r = op_a ^ op_b;
      OP_AND:  alu_r = op_a & op_b;
      OP_OR:   alu_r = op_a | op_b;
      OP_MIN:  alu_r = lt_s ? op_a : op_b;
      OP_MAX:  alu_r = lt_s ? op_b : op_a;
      OP_MINU: alu_r = lt_u ? op_a : op_b;
      OP_MAXU: alu_r = lt_u ? op_b : op_a;
      default: alu_r = op_a;
    endcase
    amo_result = word_op ? {2{alu_r[31:0]}} : alu_r;
  end
endmodule
